// File: rtl/sonar_pkg.sv
//------------------------------------------------------------------------------
// sonar_pkg : shared FSM encoding, timing constants and helpers for sonar_ranger
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GUARD     = 3'd4
  } state_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_TRIG_CYC    = 1500;
  localparam int DEF_TIMEOUT_CYC = 600000;
  localparam int DEF_GUARD_CYC   = 3000;

  // Short timing set so a full multi-channel sequence fits in a quick simulation
  localparam int SIM_TRIG_CYC    = 20;
  localparam int SIM_TIMEOUT_CYC = 1000;
  localparam int SIM_GUARD_CYC   = 50;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sonar_echo_sync.sv
//------------------------------------------------------------------------------
// sonar_echo_sync : two-flop synchroniser for one echo pin with rise/fall pulses
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sonar_echo_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/sonar_ranger.sv
//------------------------------------------------------------------------------
// sonar_ranger : round-robin multi-channel trig/echo ranging engine
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sonar_ranger
  import sonar_pkg::*;
#(
  parameter  int N_CH        = DEF_N_CH,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int TRIG_CYC    = DEF_TRIG_CYC,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter  int GUARD_CYC   = DEF_GUARD_CYC,
  localparam int CH_W        = clog2_min1(N_CH)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             fire_i,
  input  logic [N_CH-1:0]  ch_mask_i,
  output logic [N_CH-1:0]  trig_o,
  input  logic [N_CH-1:0]  echo_i,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic [CH_W-1:0]  res_ch_o,
  output logic [CNT_W-1:0] res_data_o,
  output logic             res_timeout_o,
  output logic             seq_done_o
);

  localparam int MAX_CYC = max3(TRIG_CYC, TIMEOUT_CYC, GUARD_CYC);
  localparam int PH_W    = clog2_min1(MAX_CYC + 1);

  localparam logic [PH_W-1:0] TRIG_LAST    = PH_W'(TRIG_CYC - 1);
  localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(TIMEOUT_CYC - 1);
  localparam logic [PH_W-1:0] TIMEOUT_VAL  = PH_W'(TIMEOUT_CYC);
  localparam logic [PH_W-1:0] GUARD_LAST   = PH_W'(GUARD_CYC - 1);

  state_e           state_q;
  logic [N_CH-1:0]  mask_q;
  logic [N_CH-1:0]  trig_q;
  logic [CH_W-1:0]  ch_q;
  logic [PH_W-1:0]  ph_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             busy_q;
  logic             res_valid_q;
  logic [CH_W-1:0]  res_ch_q;
  logic [CNT_W-1:0] res_data_q;
  logic             res_timeout_q;
  logic             seq_done_q;

  logic [N_CH-1:0]  w_rise;
  logic [N_CH-1:0]  w_fall;
  logic [N_CH-1:0]  w_above;
  logic             w_more;
  logic [CH_W-1:0]  w_first_ch;
  logic [CH_W-1:0]  w_next_ch;
  logic             w_rise_sel;
  logic             w_fall_sel;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    sonar_echo_sync u_sync (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .echo_i  (echo_i[g]),
      .rise_o  (w_rise[g]),
      .fall_o  (w_fall[g])
    );
  end

  // Remaining channels are those in the latched mask strictly above the current one
  always_comb begin
    w_above = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_above[i] = mask_q[i] && (i > int'(ch_q));
    end
  end

  assign w_more     = |w_above;
  assign w_first_ch = CH_W'(lowest_set(16'(ch_mask_i)));
  assign w_next_ch  = CH_W'(lowest_set(16'(w_above)));
  assign w_rise_sel = w_rise[ch_q];
  assign w_fall_sel = w_fall[ch_q];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      trig_q        <= '0;
      ch_q          <= '0;
      ph_q          <= '0;
      wcnt_q        <= '0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      seq_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fire_i && |ch_mask_i) begin
            mask_q  <= ch_mask_i;
            ch_q    <= w_first_ch;
            trig_q  <= N_CH'(1) << w_first_ch;
            busy_q  <= 1'b1;
            ph_q    <= '0;
            state_q <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (ph_q == TRIG_LAST) begin
            trig_q  <= '0;
            ph_q    <= '0;
            state_q <= ST_WAIT_RISE;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (w_rise_sel) begin
            wcnt_q  <= CNT_W'(1);
            ph_q    <= PH_W'(1);
            state_q <= ST_MEASURE;
          end else if (ph_q == TIMEOUT_LAST) begin
            res_valid_q   <= 1'b1;
            res_ch_q      <= ch_q;
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            ph_q          <= '0;
            state_q       <= ST_GUARD;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          // Timeout wins a tie with the falling edge: a pulse of exactly TIMEOUT_CYC is over-range
          if (ph_q == TIMEOUT_VAL || w_fall_sel) begin
            res_valid_q   <= 1'b1;
            res_ch_q      <= ch_q;
            res_data_q    <= wcnt_q;
            res_timeout_q <= (ph_q == TIMEOUT_VAL);
            ph_q          <= '0;
            state_q       <= ST_GUARD;
          end else begin
            ph_q <= ph_q + 1'b1;
            if (wcnt_q != '1) wcnt_q <= wcnt_q + 1'b1;
          end
        end
        ST_GUARD: begin
          if (ph_q == GUARD_LAST) begin
            ph_q <= '0;
            if (w_more) begin
              ch_q    <= w_next_ch;
              trig_q  <= N_CH'(1) << w_next_ch;
              state_q <= ST_TRIG;
            end else begin
              busy_q     <= 1'b0;
              seq_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign res_valid_o   = res_valid_q;
  assign res_ch_o      = res_ch_q;
  assign res_data_o    = res_data_q;
  assign res_timeout_o = res_timeout_q;
  assign seq_done_o    = seq_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sonar_ranger.sv
//------------------------------------------------------------------------------
// tb_sonar_ranger : timeline-model bench for sonar_ranger with random echoes
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sonar_ranger;
  import sonar_pkg::*;

  localparam int NCH  = 4;
  localparam int TRIG = SIM_TRIG_CYC;
  localparam int TMO  = SIM_TIMEOUT_CYC;
  localparam int GRD  = SIM_GUARD_CYC;
  localparam int MAXL = 8000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        fire;
  logic [3:0]  ch_mask;
  logic [3:0]  trig;
  logic [3:0]  echo;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [23:0] res_data;
  logic        res_timeout;
  logic        seq_done;

  always #5 clk_sys = ~clk_sys;

  sonar_ranger #(
    .N_CH        (NCH),
    .CNT_W       (24),
    .TRIG_CYC    (TRIG),
    .TIMEOUT_CYC (TMO),
    .GUARD_CYC   (GRD)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .fire_i        (fire),
    .ch_mask_i     (ch_mask),
    .trig_o        (trig),
    .echo_i        (echo),
    .busy_o        (busy),
    .res_valid_o   (res_valid),
    .res_ch_o      (res_ch),
    .res_data_o    (res_data),
    .res_timeout_o (res_timeout),
    .seq_done_o    (seq_done)
  );

  // Expected per-cycle timeline; cycle 0 is the first cycle after fire is accepted
  logic [3:0] e_trig [MAXL];
  bit         e_busy [MAXL];
  bit         e_valid[MAXL];
  bit         e_done [MAXL];
  int         e_ch   [MAXL];
  int         e_data [MAXL];
  bit         e_to   [MAXL];
  int         v_ch   [MAXL];
  int         v_data [MAXL];
  bit         v_to   [MAXL];
  logic [3:0] s_echo [MAXL];
  logic [3:0] s_own  [MAXL];

  // Echo plan per channel: 0 never rises, 1 pulse (delay a, width h), 2 high before trig, 3 rises and sticks
  int kind_p[NCH];
  int a_p[NCH];
  int h_p[NCH];

  int hold_ch, hold_data;
  bit hold_to;
  int end_c;
  int cur_t;
  bit active;
  int cap_n, done_cnt;
  int cap_ch[8], cap_data[8], cap_t[8];
  bit cap_to[8];
  int n_checks, n_errors;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, cur_t);
    end
  endfunction

  task automatic build(input logic [3:0] mask, output int len);
    int b, w, r, m, dat;
    bit to;
    for (int i = 0; i < MAXL; i++) begin
      e_trig[i] = '0; e_busy[i] = 0; e_valid[i] = 0; e_done[i] = 0;
      s_echo[i] = '0; s_own[i] = '0; v_ch[i] = 0; v_data[i] = 0; v_to[i] = 0;
    end
    b = 0;
    for (int c = 0; c < NCH; c++) begin
      if (!mask[c]) continue;
      w = b + TRIG;
      case (kind_p[c])
        1: begin
          m   = (h_p[c] < TMO) ? h_p[c] : TMO;
          r   = w + a_p[c] + 3 + m;
          dat = m;
          to  = (h_p[c] >= TMO);
        end
        3: begin
          r = w + a_p[c] + 3 + TMO; dat = TMO; to = 1;
        end
        default: begin
          r = w + TMO; dat = 0; to = 1;
        end
      endcase
      for (int t = b; t < r + GRD; t++) begin
        s_own[t][c] = 1'b1;
        if (t < w) begin
          e_trig[t][c] = 1'b1;
          s_echo[t][c] = (kind_p[c] == 2);
        end else if (t < r) begin
          case (kind_p[c])
            1:       s_echo[t][c] = (t >= w + a_p[c]) && (t < w + a_p[c] + h_p[c]);
            2:       s_echo[t][c] = 1'b1;
            3:       s_echo[t][c] = (t >= w + a_p[c]);
            default: s_echo[t][c] = 1'b0;
          endcase
        end
      end
      e_valid[r] = 1; v_ch[r] = c; v_data[r] = dat; v_to[r] = to;
      b = r + GRD;
    end
    end_c = b;
    e_done[b] = 1;
    len = b + 6;
    for (int t = 0; t < len; t++) begin
      e_busy[t] = (t < b);
      if (e_valid[t]) begin
        hold_ch = v_ch[t]; hold_data = v_data[t]; hold_to = v_to[t];
      end
      e_ch[t] = hold_ch; e_data[t] = hold_data; e_to[t] = hold_to;
    end
  endtask

  task automatic run_seq(input logic [3:0] mask, input bit extra, input int stop_at);
    int len;
    logic [3:0] noise;
    build(mask, len);
    noise = echo;
    cap_n = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cap_ch[i] = -1; cap_data[i] = -1; cap_t[i] = -1; cap_to[i] = 0;
    end
    @(posedge clk_sys); #1;
    fire = 1'b1; ch_mask = mask;
    for (int t = 0; t < len; t++) begin
      @(posedge clk_sys); #1;
      if (t == stop_at) begin
        active = 0; fire = 1'b0;
        return;
      end
      fire = 1'b0;
      ch_mask = 4'($urandom);
      if (extra && t < end_c && $urandom_range(0, 39) == 0) fire = 1'b1;
      if (t == end_c + 2) begin
        fire = 1'b1; ch_mask = 4'd0;
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) noise[c] = ~noise[c];
      end
      echo = (s_own[t] & s_echo[t]) | (~s_own[t] & noise);
      cur_t = t; active = 1;
    end
    @(posedge clk_sys); #1;
    active = 0; fire = 1'b0;
  endtask

  task automatic do_reset_mid(input int stop_at, input bit exp_trig);
    kind_p[0] = 1; a_p[0] = 5; h_p[0] = 600;
    run_seq(4'b0001, 0, stop_at);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_trig", trig[0], exp_trig);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    repeat (3) begin
      @(negedge clk_sys);
      chk("rst_quiet", {res_valid, seq_done, busy}, 0);
    end
    @(posedge clk_sys); #3;
    rst_n = 1'b1;
    hold_ch = 0; hold_data = 0; hold_to = 0;
  endtask

  always @(negedge clk_sys) begin
    if (active) begin
      chk("trig",        trig,        e_trig[cur_t]);
      chk("busy",        busy,        e_busy[cur_t]);
      chk("res_valid",   res_valid,   e_valid[cur_t]);
      chk("seq_done",    seq_done,    e_done[cur_t]);
      chk("res_ch",      res_ch,      e_ch[cur_t]);
      chk("res_data",    res_data,    e_data[cur_t]);
      chk("res_timeout", res_timeout, e_to[cur_t]);
      if (res_valid && cap_n < 8) begin
        cap_ch[cap_n] = res_ch; cap_data[cap_n] = res_data;
        cap_to[cap_n] = res_timeout; cap_t[cap_n] = cur_t;
        cap_n++;
      end
      if (seq_done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fire = 1'b0; ch_mask = '0; echo = '0;
    active = 0; cur_t = 0; n_checks = 0; n_errors = 0;
    hold_ch = 0; hold_data = 0; hold_to = 0;
    cap_n = 0; done_cnt = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_trig",     trig,        0);
    chk("reset_busy",     busy,        0);
    chk("reset_valid",    res_valid,   0);
    chk("reset_data",     res_data,    0);
    chk("reset_timeout",  res_timeout, 0);
    chk("reset_seq_done", seq_done,    0);
    @(posedge clk_sys); #3;
    rst_n = 1'b1;

    // Single channel, 300-cycle echo starting 10 cycles after trig falls
    kind_p[0] = 1; a_p[0] = 10; h_p[0] = 300;
    run_seq(4'b0001, 0, -1);
    chk("d1_count", cap_n, 1);
    chk("d1_ch", cap_ch[0], 0);
    chk("d1_data", cap_data[0], 300);
    chk("d1_to", cap_to[0], 0);
    chk("d1_time", cap_t[0], 20 + 10 + 3 + 300);
    chk("d1_done", done_cnt, 1);

    // Two channels in order, with stray fires during the sequence
    kind_p[1] = 1; a_p[1] = 30; h_p[1] = 100;
    kind_p[3] = 1; a_p[3] = 30; h_p[3] = 200;
    run_seq(4'b1010, 1, -1);
    chk("d2_count", cap_n, 2);
    chk("d2_ch0", cap_ch[0], 1);
    chk("d2_ch1", cap_ch[1], 3);
    chk("d2_data0", cap_data[0], 100);
    chk("d2_data1", cap_data[1], 200);
    chk("d2_gap_ge_50", (cap_t[1] - cap_t[0]) >= 50, 1);
    chk("d2_done", done_cnt, 1);

    // No echo at all
    kind_p[2] = 0;
    run_seq(4'b0100, 0, -1);
    chk("d3_ch", cap_ch[0], 2);
    chk("d3_data", cap_data[0], 0);
    chk("d3_to", cap_to[0], 1);
    chk("d3_time", cap_t[0], 20 + 1000);

    // Echo already high before the channel starts listening
    kind_p[1] = 2;
    run_seq(4'b0010, 0, -1);
    chk("d4_data", cap_data[0], 0);
    chk("d4_to", cap_to[0], 1);

    // Echo rises and never falls
    kind_p[1] = 3; a_p[1] = 5;
    run_seq(4'b0010, 0, -1);
    chk("d5_data", cap_data[0], 1000);
    chk("d5_to", cap_to[0], 1);

    // Width just below and exactly at the timeout
    kind_p[0] = 1; a_p[0] = 0; h_p[0] = 999;
    run_seq(4'b0001, 0, -1);
    chk("d6_data", cap_data[0], 999);
    chk("d6_to", cap_to[0], 0);
    kind_p[0] = 1; a_p[0] = 0; h_p[0] = 1000;
    run_seq(4'b0001, 0, -1);
    chk("d7_data", cap_data[0], 1000);
    chk("d7_to", cap_to[0], 1);

    // Reset during TRIG and during MEASURE, then a clean run
    do_reset_mid(5, 1);
    do_reset_mid(200, 0);
    kind_p[0] = 1; a_p[0] = 4; h_p[0] = 77;
    run_seq(4'b0001, 0, -1);
    chk("d8_count", cap_n, 1);
    chk("d8_data", cap_data[0], 77);
    chk("d8_to", cap_to[0], 0);

    // Randomised sequences
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < NCH; c++) begin
        int sel;
        sel = $urandom_range(0, 9);
        a_p[c] = $urandom_range(0, 200);
        case (sel)
          0:       kind_p[c] = 0;
          1:       kind_p[c] = 2;
          2:       kind_p[c] = 3;
          3:       begin kind_p[c] = 1; h_p[c] = $urandom_range(990, 1010); end
          default: begin kind_p[c] = 1; h_p[c] = $urandom_range(1, 300); end
        endcase
      end
      run_seq(4'($urandom_range(1, 15)), 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
